// File: rtl/cpu_result_uart_logger.sv
// cpu_result_uart_logger: logs CPU result words through a FIFO as LSB-first UART frames
// Ports: clk, rst_n (async active-low); ena freezes all state; cap_valid/cap_data push a word;
// clr_ovf clears the sticky overflow flag; tx_out serial line (idle high); tx_busy frame in progress;
// fifo_count stored unsent words; overflow set when a capture meets a full FIFO.
// Define LOGGER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module cpu_result_uart_logger #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    cap_valid,
    input  logic [7:0]              cap_data,
    input  logic                    clr_ovf,
    output logic                    tx_out,
    output logic                    tx_busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, tx_q, tx_d, busy_q, busy_d;
    logic [7:0]    mem_q [DEPTH];
    logic          full, push, pop, last;
`ifdef LOGGER_PARITY_EN
    logic          par_q, par_d;
`endif
    always_comb begin
        full    = count_q == (AW+1)'(DEPTH);
        push    = cap_valid && !full;
        pop     = state_q == IDLE && count_q != '0;
        last    = baud_q == BW'(CLKS_PER_BIT - 1);
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // a drop at the same edge as a clear keeps the flag set
        ovf_d   = (cap_valid && full) || (ovf_q && !clr_ovf);
        baud_d  = (state_q == IDLE || last) ? '0 : baud_q + BW'(1);
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef LOGGER_PARITY_EN
        par_d   = par_q;
`endif
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_q];
            bit_d   = '0;
`ifdef LOGGER_PARITY_EN
            par_d   = ^mem_q[rd_q];
`endif
        end else if (state_q != IDLE && last) begin
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
`ifdef LOGGER_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
`ifdef LOGGER_PARITY_EN
                PARITY: state_d = STOP;
`endif
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
        // tx_out is registered from the next state so the line never sees cap_* combinationally
`ifdef LOGGER_PARITY_EN
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef LOGGER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (ena) begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef LOGGER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (ena && push) mem_q[wr_q] <= cap_data;
    end
    assign tx_out     = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_cpu_result_uart_logger.sv
// tb_cpu_result_uart_logger: directed and random stimulus against a frame-level reference model
module tb_cpu_result_uart_logger;
    localparam int DEPTH = 4;
    localparam int C     = 4;
`ifdef LOGGER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;
    logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, cap_valid = 1'b0, clr_ovf = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic tx_out, tx_busy, overflow;
    logic [$clog2(DEPTH):0] fifo_count;
    int checks = 0, passes = 0;
    logic [7:0] q[$];
    int t = 0;
    logic [7:0] w = 8'h00;
    logic movf = 1'b0;
    cpu_result_uart_logger #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cap_valid(cap_valid), .cap_data(cap_data),
        .clr_ovf(clr_ovf), .tx_out(tx_out), .tx_busy(tx_busy), .fifo_count(fifo_count),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask
    function automatic logic exp_tx();
        int b;
        if (t == 0) return 1'b1;
        b = (FRAME - t) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (NB == 11 && b == 9) return ^w;
        return 1'b1;
    endfunction
    task automatic model_reset();
        q.delete();
        t = 0;
        w = 8'h00;
        movf = 1'b0;
    endtask
    task automatic model_edge(input logic e, input logic v, input logic [7:0] d, input logic c);
        int pre;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!e) return;
        pre = q.size();
        if (t == 0 && pre != 0) begin
            w = q.pop_front();
            t = FRAME;
        end else if (t > 0) t--;
        if (c) movf = 1'b0;
        if (v) begin
            if (pre < DEPTH) q.push_back(d);
            else movf = 1'b1;
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".tx_out"}, 32'(tx_out), 32'(exp_tx()));
        chk({tag, ".tx_busy"}, 32'(tx_busy), 32'(t > 0));
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
    endtask
    task automatic cyc(input logic e, input logic v, input logic [7:0] d, input logic c, input string tag);
        ena = e;
        cap_valid = v;
        cap_data = d;
        clr_ovf = c;
        @(posedge clk);
        model_edge(e, v, d, c);
        #1;
        check_all(tag);
    endtask
    initial begin
        int nb;
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        cyc(1, 1, 8'hFF, 0, "reset_hold");
        cyc(1, 1, 8'hFF, 0, "reset_hold");
        rst_n = 1'b1;
        repeat (3) cyc(1, 0, 8'h00, 0, "idle");
        // single word 0xA5
        cyc(1, 1, 8'hA5, 0, "a5_push");
        chk("a5_count_after_push", 32'(fifo_count), 32'd1);
        nb = 0;
        repeat (FRAME + 5) begin
            cyc(1, 0, 8'h00, 0, "a5_frame");
            if (tx_busy) nb++;
        end
        chk("a5_busy_len", 32'(nb), 32'(FRAME));
        // overflow: six consecutive pushes
        for (int i = 0; i < 6; i++) cyc(1, 1, 8'(8'h10 + i), 0, "ovf_push");
        chk("ovf_count_full", 32'(fifo_count), 32'd4);
        chk("ovf_flag_set", 32'(overflow), 32'd1);
        cyc(1, 1, 8'h55, 1, "ovf_set_wins");
        chk("ovf_set_wins_direct", 32'(overflow), 32'd1);
        cyc(1, 0, 8'h00, 1, "ovf_clear");
        chk("ovf_clear_direct", 32'(overflow), 32'd0);
        repeat (5 * (FRAME + 1) + 5) cyc(1, 0, 8'h00, 0, "ovf_drain");
        chk("ovf_drained", 32'(fifo_count), 32'd0);
        // enable freeze during data bit 3 of 0x3C
        cyc(1, 1, 8'h3C, 0, "frz_push");
        repeat (4 * C + 1) cyc(1, 0, 8'h00, 0, "frz_pre");
        for (int i = 0; i < 7; i++) begin
            cyc(0, i[0], 8'hE7, 0, "frz_hold");
            chk("frz_bit3", 32'(tx_out), 32'd1);
        end
        repeat (FRAME + 4) cyc(1, 0, 8'h00, 0, "frz_post");
        chk("frz_nothing_stored", 32'(fifo_count), 32'd0);
        // parity words (plain frames when the option is off)
        cyc(1, 1, 8'h07, 0, "par_push0");
        cyc(1, 1, 8'h03, 0, "par_push1");
        repeat (2 * (FRAME + 1) + 4) cyc(1, 0, 8'h00, 0, "par_frames");
        // random traffic
        repeat (600) cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, 8'($urandom),
                         $urandom_range(0, 19) == 0, "rand");
        repeat (DEPTH * (FRAME + 1) + 10) cyc(1, 0, 8'h00, 0, "rand_drain");
        // asynchronous reset in the middle of a frame
        cyc(1, 1, 8'h96, 0, "rst_push");
        cyc(1, 1, 8'h69, 0, "rst_push");
        repeat (10) cyc(1, 0, 8'h00, 0, "rst_pre");
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        cyc(1, 1, 8'h11, 0, "rst_low");
        rst_n = 1'b1;
        cyc(1, 1, 8'h5A, 0, "rst_after_push");
        repeat (FRAME + 5) cyc(1, 0, 8'h00, 0, "rst_after");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
